// File: rtl/scaler_linear_h_mc.sv
// scaler_linear_h_mc: horizontal linear-interpolation scaler with multi-channel pixels.
// Input positions advance by PIXEL_STEP per pixel; output positions advance by the
// per-line step. Each output blends the two most recent input pixels. The pipeline is
// input reg -> decision/weight reg -> multiply reg -> sum reg -> output reg.
module scaler_linear_h_mc #(
  parameter int PIXEL_STEP  = 4096,
  parameter int PIXEL_WIDTH = 12,
  parameter int COE_WIDTH   = 10,
  parameter int CHANNELS    = 3,
  parameter int CNT_WIDTH   = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [15:0]                     h_scale_step,
  input  logic                            bypass,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [CHANNELS*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic                            overrun_o
);

  localparam int F  = $clog2(PIXEL_STEP);
  localparam int SH = F - COE_WIDTH + 1;
  localparam int PW = PIXEL_WIDTH;
  localparam int CW = COE_WIDTH;
  localparam int MW = PW + CW;
  localparam int DW = CHANNELS * PW;
  localparam logic [CW-1:0]        UNITY   = {1'b1, {(CW-1){1'b0}}};
  localparam logic [MW:0]          HALF    = {{(MW-CW+2){1'b0}}, 1'b1, {(CW-2){1'b0}}};
  localparam logic [MW:0]          PMAX    = {{(CW+1){1'b0}}, {PW{1'b1}}};
  localparam logic [CNT_WIDTH-1:0] STEP_C  = CNT_WIDTH'(PIXEL_STEP);
  localparam logic [CNT_WIDTH-1:0] UNITY_C = CNT_WIDTH'(UNITY);

  // stage 1: registered inputs
  logic [DW-1:0] di1_d, di1_q;
  logic          de1_d, de1_q, hs1_d, hs1_q, vs1_d, vs1_q, byp1_d, byp1_q;
  logic [15:0]   stp1_d, stp1_q;
  // line state
  logic [CNT_WIDTH-1:0] cnt_i_d, cnt_i_q, cnt_o_d, cnt_o_q;
  logic [15:0]          step_d, step_q;
  logic [DW-1:0]        cur_d, cur_q, prev_d, prev_q;
  logic                 armed_d, armed_q, mode_d, mode_q, ovf_d, ovf_q;
  // stage 2: decision / weight
  logic          v2_d, v2_q, hs2_d, hs2_q, vs2_d, vs2_q;
  logic [CW-1:0] w2_d, w2_q;
  logic [DW-1:0] cur2_d, cur2_q, prev2_d, prev2_q;
  // stage 3: products
  logic                         v3_d, v3_q, hs3_d, hs3_q, vs3_d, vs3_q;
  logic [CHANNELS-1:0][MW-1:0]  mp3_d, mp3_q, mc3_d, mc3_q;
  // stage 4: rounded sums
  logic                         v4_d, v4_q, hs4_d, hs4_q, vs4_d, vs4_q;
  logic [CHANNELS-1:0][MW:0]    sum4_d, sum4_q;
  // stage 5: outputs
  logic [DW-1:0] do_d, do_q;
  logic          de_o_d, de_o_q, hs_o_d, hs_o_q, vs_o_d, vs_o_q;
  // combinational helpers
  logic                 line_start_s, pix_s, emit_s, ovf_pend_s;
  logic [CNT_WIDTH-1:0] cnt_o_b_s, d_s, a_s;
  logic [CW-1:0]        w_s;
  logic [MW:0]          out_s;

  // next-state logic for every pipeline stage and the line position state
  always_comb begin
    di1_d  = di_i;
    de1_d  = de_i;
    hs1_d  = hs_i;
    vs1_d  = vs_i;
    byp1_d = bypass;
    stp1_d = h_scale_step;

    // a line start rewinds both positions and replicates the first pixel
    line_start_s = de1_q & hs1_q;
    pix_s        = de1_q & ~hs1_q & armed_q;
    armed_d      = armed_q | line_start_s;
    mode_d       = mode_q;
    step_d       = step_q;
    cnt_i_d      = cnt_i_q;
    cnt_o_b_s    = cnt_o_q;
    cur_d        = cur_q;
    prev_d       = prev_q;
    if (line_start_s) begin
      mode_d    = byp1_q | (stp1_q == 16'd0);
      step_d    = stp1_q;
      cnt_i_d   = '0;
      cnt_o_b_s = '0;
      cur_d     = di1_q;
      prev_d    = di1_q;
    end else if (pix_s) begin
      cnt_i_d = cnt_i_q + STEP_C;
      cur_d   = di1_q;
      prev_d  = cur_q;
    end else begin
      cnt_i_d = cnt_i_q;
    end

    // bypass lines forward every pixel; scaled lines emit while the output position is reached
    if (mode_d) begin
      emit_s = line_start_s | pix_s;
    end else begin
      emit_s = armed_d & (cnt_i_d >= cnt_o_b_s);
    end
    if (emit_s && !mode_d) begin
      cnt_o_d = cnt_o_b_s + {{(CNT_WIDTH-16){1'b0}}, step_d};
    end else begin
      cnt_o_d = cnt_o_b_s;
    end

    // distance behind the newest pixel becomes the weight of the older pixel, saturated at unity
    d_s = cnt_i_d - cnt_o_b_s;
    a_s = d_s >> SH;
    if (mode_d) begin
      w_s = '0;
    end else if (a_s > UNITY_C) begin
      w_s = UNITY;
    end else begin
      w_s = a_s[CW-1:0];
    end

    // more than one output still pending when a new pixel arrives is a rate violation
    ovf_pend_s = ({1'b0, cnt_i_q} >= ({1'b0, cnt_o_q} + {{(CNT_WIDTH-15){1'b0}}, step_q}));
    ovf_d      = ovf_q | (pix_s & ~mode_q & ovf_pend_s);

    v2_d    = emit_s;
    hs2_d   = emit_s & line_start_s;
    vs2_d   = emit_s & line_start_s & vs1_q;
    w2_d    = w_s;
    cur2_d  = cur_d;
    prev2_d = prev_d;

    v3_d  = v2_q;
    hs3_d = hs2_q;
    vs3_d = vs2_q;
    v4_d  = v3_q;
    hs4_d = hs3_q;
    vs4_d = vs3_q;
    for (int c = 0; c < CHANNELS; c++) begin
      mp3_d[c]  = {{CW{1'b0}}, prev2_q[c*PW +: PW]} * {{PW{1'b0}}, w2_q};
      mc3_d[c]  = {{CW{1'b0}}, cur2_q[c*PW +: PW]} * {{PW{1'b0}}, UNITY - w2_q};
      sum4_d[c] = {1'b0, mp3_q[c]} + {1'b0, mc3_q[c]} + HALF;
    end

    // output register holds its value between valid outputs
    out_s  = '0;
    do_d   = do_q;
    de_o_d = v4_q;
    hs_o_d = hs4_q;
    vs_o_d = vs4_q;
    if (v4_q) begin
      for (int c = 0; c < CHANNELS; c++) begin
        out_s = sum4_q[c] >> (CW-1);
        if (out_s > PMAX) begin
          do_d[c*PW +: PW] = {PW{1'b1}};
        end else begin
          do_d[c*PW +: PW] = out_s[PW-1:0];
        end
      end
    end else begin
      do_d = do_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      di1_q <= '0; de1_q <= 1'b0; hs1_q <= 1'b0; vs1_q <= 1'b0; byp1_q <= 1'b0; stp1_q <= '0;
      cnt_i_q <= '0; cnt_o_q <= '0; step_q <= '0; cur_q <= '0; prev_q <= '0;
      armed_q <= 1'b0; mode_q <= 1'b0; ovf_q <= 1'b0;
      v2_q <= 1'b0; hs2_q <= 1'b0; vs2_q <= 1'b0; w2_q <= '0; cur2_q <= '0; prev2_q <= '0;
      v3_q <= 1'b0; hs3_q <= 1'b0; vs3_q <= 1'b0; mp3_q <= '0; mc3_q <= '0;
      v4_q <= 1'b0; hs4_q <= 1'b0; vs4_q <= 1'b0; sum4_q <= '0;
      do_q <= '0; de_o_q <= 1'b0; hs_o_q <= 1'b0; vs_o_q <= 1'b0;
    end else begin
      di1_q <= di1_d; de1_q <= de1_d; hs1_q <= hs1_d; vs1_q <= vs1_d; byp1_q <= byp1_d; stp1_q <= stp1_d;
      cnt_i_q <= cnt_i_d; cnt_o_q <= cnt_o_d; step_q <= step_d; cur_q <= cur_d; prev_q <= prev_d;
      armed_q <= armed_d; mode_q <= mode_d; ovf_q <= ovf_d;
      v2_q <= v2_d; hs2_q <= hs2_d; vs2_q <= vs2_d; w2_q <= w2_d; cur2_q <= cur2_d; prev2_q <= prev2_d;
      v3_q <= v3_d; hs3_q <= hs3_d; vs3_q <= vs3_d; mp3_q <= mp3_d; mc3_q <= mc3_d;
      v4_q <= v4_d; hs4_q <= hs4_d; vs4_q <= vs4_d; sum4_q <= sum4_d;
      do_q <= do_d; de_o_q <= de_o_d; hs_o_q <= hs_o_d; vs_o_q <= vs_o_d;
    end
  end

  assign do_o      = do_q;
  assign de_o      = de_o_q;
  assign hs_o      = hs_o_q;
  assign vs_o      = vs_o_q;
  assign overrun_o = ovf_q;

endmodule

// File: tb/tb_scaler_linear_h_mc.sv
// Bench for scaler_linear_h_mc: drives lines of pixels and compares every output against
// a position-based reference model (output k sits at k*step, input j at j*PIXEL_STEP).
`timescale 1ns/1ps
module tb_scaler_linear_h_mc;
  localparam int PW = 12;
  localparam int CH = 3;
  localparam int DW = CH * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   h_scale_step = 16'd0;
  logic          bypass = 1'b0;
  logic [DW-1:0] di_i = '0;
  logic          de_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [DW-1:0] do_o;
  logic          de_o, hs_o, vs_o, overrun_o;

  scaler_linear_h_mc dut (
    .clk(clk), .rst(rst), .h_scale_step(h_scale_step), .bypass(bypass),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
    .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int            n_cmp = 0, n_err = 0, n_out = 0;
  bit            exp_ovf = 1'b0;
  logic [DW-1:0] last_do = '0;
  typedef struct { int cyc; logic [DW-1:0] data; logic hs; logic vs; } exp_t;
  exp_t          expq[$];
  exp_t          mon_e;
  logic [DW-1:0] pix[64];
  int            arr[64];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_pix();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // reference blend: weight of the older pixel is the distance behind the newest one
  function automatic logic [DW-1:0] interp(input logic [DW-1:0] p, input logic [DW-1:0] c, input longint d);
    logic [DW-1:0] r;
    longint a, pv, cv, v;
    r = '0;
    a = d / 8;
    if (a > 512) a = 512;
    for (int ch = 0; ch < CH; ch++) begin
      pv = longint'(p[ch*PW +: PW]);
      cv = longint'(c[ch*PW +: PW]);
      v  = (pv * a + cv * (512 - a) + 256) / 512;
      if (v > 4095) v = 4095;
      r[ch*PW +: PW] = 12'(v);
    end
    return r;
  endfunction

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_q) begin
      expq.delete();
      last_do = '0;
      check_eq("rst_outs", {de_o, hs_o, vs_o, overrun_o, do_o}, 64'd0);
    end else if (de_o) begin
      n_out++;
      if (expq.size() == 0) begin
        check_eq("spurious_de_o", de_o, 1'b0);
      end else begin
        mon_e = expq.pop_front();
        check_eq("de_time", cyc, mon_e.cyc);
        check_eq("do", do_o, mon_e.data);
        check_eq("hs_o", hs_o, mon_e.hs);
        check_eq("vs_o", vs_o, mon_e.vs);
        last_do = mon_e.data;
      end
    end else begin
      check_eq("hold_do", do_o, last_do);
      check_eq("idle_sync", {hs_o, vs_o}, 2'b00);
    end
  end

  task automatic drive(input logic de, input logic hs, input logic vs, input logic [DW-1:0] d,
                       input logic [15:0] st, input logic by);
    @(posedge clk);
    #1;
    de_i = de; hs_i = hs; vs_i = vs; di_i = d; h_scale_step = st; bypass = by;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_pix(),
            16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1; de_i = 1'b0; hs_i = 1'b0;
    idle(n);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // drive pix[0..n-1] at cycle offsets arr[], predicting outputs cycle by cycle
  task automatic run_line(input int n, input logic [15:0] step, input logic byp, input logic vs);
    int     jl, pj, tend;
    longint k, st;
    bit     bm, arrive;
    exp_t   e;
    jl = -1; k = 0; st = longint'(step);
    bm = byp || (step == 16'd0);
    tend = arr[n-1] + 40;
    for (int c = 0; c < tend; c++) begin
      arrive = (jl + 1 < n) && (arr[jl+1] == c);
      if (arrive) begin
        if (jl >= 0 && !bm && (longint'(jl) * 4096 >= k * st + st)) exp_ovf = 1'b1;
        jl++;
        if (jl == 0) drive(1'b1, 1'b1, vs, pix[0], step, byp);
        else drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), pix[jl], 16'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        idle(1);
      end
      if (jl >= 0) begin
        if (bm) begin
          if (arrive) begin
            e.cyc = cyc + 5; e.data = pix[jl]; e.hs = (jl == 0); e.vs = vs && (jl == 0);
            expq.push_back(e);
          end
        end else if (longint'(jl) * 4096 >= k * st) begin
          pj = (jl == 0) ? 0 : jl - 1;
          e.cyc = cyc + 5; e.data = interp(pix[pj], pix[jl], longint'(jl) * 4096 - k * st);
          e.hs = (k == 0); e.vs = vs && (k == 0);
          expq.push_back(e);
          k++;
        end
      end
    end
    check_eq("drain", expq.size(), 0);
    check_eq("overrun", overrun_o, exp_ovf);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int            o0, n, sp;
    logic [11:0]   v;
    logic [15:0]   st;
    logic [DW-1:0] pv;
    exp_t          e;

    idle(3);
    rst = 1'b0;
    // pixels before any line start must be ignored
    for (int j = 0; j < 6; j++) drive(1'b1, 1'b0, 1'b0, rand_pix(), 16'd4096, 1'b0);
    idle(10);
    check_eq("unarmed_outs", n_out, 0);

    // unity step: identity, one output per pixel
    for (int j = 0; j < 10; j++) begin v = 12'(j); pix[j] = {v, v, v}; arr[j] = j; end
    o0 = n_out;
    run_line(10, 16'd4096, 1'b0, 1'b1);
    check_eq("unity_count", n_out - o0, 10);

    // 2x downscale
    for (int j = 0; j < 10; j++) begin v = 12'(100 * j); pix[j] = {v, v, v}; arr[j] = j; end
    o0 = n_out;
    run_line(10, 16'd8192, 1'b0, 1'b0);
    check_eq("down2_count", n_out - o0, 5);
    check_eq("down2_ovf", overrun_o, 1'b0);

    // 2x upscale with idle cycles between pixels
    for (int j = 0; j < 4; j++) begin v = 12'(100 * j); pix[j] = {v, v, v}; arr[j] = 2 * j; end
    o0 = n_out;
    run_line(4, 16'd2048, 1'b0, 1'b1);
    check_eq("up2_count", n_out - o0, 7);
    check_eq("up2_ovf", overrun_o, 1'b0);

    // 2x upscale back-to-back: rate violation, sticky across the next line
    for (int j = 0; j < 4; j++) arr[j] = j;
    run_line(4, 16'd2048, 1'b0, 1'b0);
    check_eq("up2_b2b_ovf", overrun_o, 1'b1);
    run_line(4, 16'd4096, 1'b0, 1'b0);
    check_eq("ovf_sticky", overrun_o, 1'b1);
    do_reset(2);
    check_eq("ovf_cleared", overrun_o, 1'b0);

    // bypass and zero-step pass-through with random pixels and gaps
    for (int t = 0; t < 2; t++) begin
      for (int j = 0; j < 16; j++) begin
        pix[j] = rand_pix();
        arr[j] = (j == 0) ? 0 : arr[j-1] + $urandom_range(1, 3);
      end
      run_line(16, (t == 0) ? 16'($urandom_range(1, 65535)) : 16'd0, t == 0, 1'b1);
    end

    // randomized scaled lines
    for (int t = 0; t < 12; t++) begin
      do_reset(1);
      n  = $urandom_range(2, 20);
      st = 16'($urandom_range(1024, 16384));
      sp = (4096 + int'(st) - 1) / int'(st);
      for (int j = 0; j < n; j++) begin
        pix[j] = rand_pix();
        arr[j] = (j == 0) ? 0 : arr[j-1] + sp + $urandom_range(0, 2);
      end
      run_line(n, st, 1'b0, 1'($urandom_range(0, 1)));
    end

    // reset mid-line: in-flight outputs flushed, no output until the next line start
    for (int j = 0; j < 8; j++) begin
      pv = rand_pix();
      drive(1'b1, j == 0, 1'b0, pv, 16'd4096, 1'b0);
      e.cyc = cyc + 5; e.data = pv; e.hs = (j == 0); e.vs = 1'b0;
      expq.push_back(e);
    end
    @(posedge clk);
    #1;
    rst = 1'b1; de_i = 1'b0; hs_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    o0 = n_out;
    for (int j = 0; j < 6; j++) drive(1'b1, 1'b0, 1'b0, rand_pix(), 16'd4096, 1'b0);
    idle(12);
    check_eq("post_rst_no_out", n_out - o0, 0);

    // normal operation resumes at the next line start
    for (int j = 0; j < 6; j++) begin pix[j] = rand_pix(); arr[j] = 2 * j; end
    run_line(6, 16'd3000, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
